// File: rtl/prbs_checker_pkg.sv
// prbs_checker_pkg -- shared definitions for the PRBS checker and the
// matching LFSR generator model.
//   state_e       : checker state (HUNT, LOCKED)
//   sanitize_tap  : replace a degenerate tap mask (all-zero/all-one) by bit 1
//   prbs_step_f   : one Galois LFSR step, next word from word and tap
// Functions work on MAX_W-bit vectors with a run-time width argument so a
// single definition serves every SIZE up to MAX_W.
package prbs_checker_pkg;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] sanitize_tap(input logic [MAX_W-1:0] tap,
                                                    input int size);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] t;
    mask = '0;
    for (int b = 0; b < MAX_W; b++)
      if (b < size) mask[b] = 1'b1;
    t = tap & mask;
    if (t == '0 || t == mask) begin
      t    = '0;
      t[1] = 1'b1;
    end
    return t;
  endfunction

  // fb includes the all-zero-below-MSB term so the all-zero word is part of
  // the sequence instead of a lock-up state.
  function automatic logic [MAX_W-1:0] prbs_step_f(input logic [MAX_W-1:0] w,
                                                   input logic [MAX_W-1:0] tap,
                                                   input int size);
    logic [MAX_W-1:0] n;
    logic             low_zero;
    logic             msb;
    logic             fb;
    low_zero = 1'b1;
    msb      = 1'b0;
    for (int b = 0; b < MAX_W; b++) begin
      if (b < size - 1 && w[b]) low_zero = 1'b0;
      if (b == size - 1)        msb      = w[b];
    end
    fb   = msb ^ low_zero;
    n    = '0;
    n[0] = fb;
    for (int b = 1; b < MAX_W; b++)
      if (b < size) n[b] = tap[b] ? (w[b-1] ^ fb) : w[b-1];
    return n;
  endfunction

endpackage

// File: rtl/prbs_checker_step.sv
// prbs_step -- combinational next LFSR word.
//   word_i : current word
//   tap_i  : already-sanitised tap mask
//   next_o : step(word_i)
module prbs_step
  import prbs_checker_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] word_i,
  input  logic [SIZE-1:0] tap_i,
  output logic [SIZE-1:0] next_o
);

  assign next_o = SIZE'(prbs_step_f(MAX_W'(word_i), MAX_W'(tap_i), SIZE));

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker -- locks onto a Galois LFSR word stream and counts errors.
//   clk       : clock, all state on posedge
//   rst       : asynchronous active-low reset
//   tap       : Galois tap mask (same encoding as the generator)
//   din_valid : din sampled this cycle
//   din       : received word
//   clr_cnt   : synchronous clear of err_cnt (wins over a same-cycle error)
//   locked    : checker is LOCKED
//   err       : one-cycle pulse per mismatching word while LOCKED
//   err_cnt   : saturating error count
// Build option: define PRBS_CHECKER_BITERR_EN to count bit errors
// (popcount of din^expected) instead of word errors.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int LOCK_CNT  = 16,
  parameter int LOSS_CNT  = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SIZE-1:0]      tap,
  input  logic                 din_valid,
  input  logic [SIZE-1:0]      din,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam int PW = $clog2(SIZE + 1);
  localparam int SW = ((ERR_CNT_W > PW) ? ERR_CNT_W : PW) + 1;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  state_e                state_q;
  logic [SIZE-1:0]       prev_q;
  logic                  prev_ok_q;
  logic [MW-1:0]         match_q;
  logic [LW-1:0]         miss_q;
  logic [SIZE-1:0]       exp_q;
  logic                  locked_q;
  logic                  err_q;
  logic [ERR_CNT_W-1:0]  cnt_q;

  logic [SIZE-1:0]       tap_s;
  logic [SIZE-1:0]       pred;
  logic [SIZE-1:0]       exp_src;
  logic [SIZE-1:0]       exp_nxt;
  logic                  mismatch;
  logic [MW-1:0]         match_inc;
  logic [LW-1:0]         miss_inc;
  logic [PW-1:0]         inc;
  logic [SW-1:0]         cnt_sum;
  logic [ERR_CNT_W-1:0]  cnt_sat;
  logic                  cnt_add;

  assign tap_s = SIZE'(sanitize_tap(MAX_W'(tap), SIZE));

  // HUNT prediction: next word after the previously received one.
  prbs_step #(.SIZE(SIZE)) u_pred (
    .word_i (prev_q),
    .tap_i  (tap_s),
    .next_o (pred)
  );

  // Expected path: in HUNT it seeds expected from the locking word, in
  // LOCKED it free-runs from the current expected word.
  assign exp_src = (state_q == LOCKED) ? exp_q : din;

  prbs_step #(.SIZE(SIZE)) u_exp (
    .word_i (exp_src),
    .tap_i  (tap_s),
    .next_o (exp_nxt)
  );

  assign mismatch  = (din != exp_q);
  assign match_inc = match_q + MW'(1);
  assign miss_inc  = miss_q + LW'(1);
  assign cnt_add   = din_valid && (state_q == LOCKED) && mismatch;

`ifdef PRBS_CHECKER_BITERR_EN
  logic [SIZE-1:0] diff;
  assign diff = din ^ exp_q;
  always_comb begin
    inc = '0;
    for (int b = 0; b < SIZE; b++) inc = inc + PW'(diff[b]);
  end
`else
  assign inc = PW'(1);
`endif

  // Widened add so saturation is detected instead of wrapping.
  assign cnt_sum = SW'(cnt_q) + SW'(inc);
  assign cnt_sat = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : cnt_sum[ERR_CNT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= HUNT;
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
      match_q   <= '0;
      miss_q    <= '0;
      exp_q     <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      err_q <= 1'b0;
      if (din_valid) begin
        case (state_q)
          HUNT: begin
            prev_q    <= din;
            prev_ok_q <= 1'b1;
            if (prev_ok_q) begin
              if (din == pred) begin
                if (match_inc == MW'(LOCK_CNT)) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                  exp_q    <= exp_nxt;
                  match_q  <= '0;
                end else begin
                  match_q <= match_inc;
                end
              end else begin
                match_q <= '0;
              end
            end
          end
          LOCKED: begin
            // Expected free-runs; received data never resyncs it.
            exp_q <= exp_nxt;
            if (mismatch) begin
              err_q <= 1'b1;
              if (miss_inc == LW'(LOSS_CNT)) begin
                state_q   <= HUNT;
                locked_q  <= 1'b0;
                prev_ok_q <= 1'b0;
                match_q   <= '0;
                miss_q    <= '0;
              end else begin
                miss_q <= miss_inc;
              end
            end else begin
              miss_q <= '0;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
      if (clr_cnt)      cnt_q <= '0;
      else if (cnt_add) cnt_q <= cnt_sat;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

  localparam int CW   = 4;
  localparam int LOCK = 16;
  localparam int LOSS = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    tap;
  logic          din_valid;
  logic [7:0]    din;
  logic          clr_cnt;
  logic          locked;
  logic          err;
  logic [CW-1:0] err_cnt;

  prbs_checker #(.SIZE(8), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .tap(tap), .din_valid(din_valid), .din(din),
    .clr_cnt(clr_cnt), .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       lk;
    logic       er;
    logic [3:0] cnt;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
  endtask

  // Independent reference step: shift, then XOR feedback into tapped bits.
  function automatic logic [7:0] tstep(input logic [7:0] w, input logic [7:0] t);
    logic fb;
    fb = w[7] ^ (w[6:0] == 7'd0);
    return {w[6:0], 1'b0} ^ ({8{fb}} & {t[7:1], 1'b1});
  endfunction

  // Reference checker model
  logic [7:0] m_tap, g;
  bit         m_lk, m_prev_ok;
  logic [7:0] m_prev, m_exp;
  int         m_match, m_miss, m_cnt;

  task automatic model_reset();
    m_lk = 0; m_prev_ok = 0; m_match = 0; m_miss = 0; m_cnt = 0;
    m_prev = '0; m_exp = '0;
  endtask

  task automatic model(input bit v, input logic [7:0] d, input bit c);
    exp_t e;
    bit   er;
    int   inc;
    er = 0; inc = 0;
    if (v) begin
      if (!m_lk) begin
        if (m_prev_ok) begin
          if (d == tstep(m_prev, m_tap)) m_match++;
          else m_match = 0;
          if (m_match == LOCK) begin
            m_lk = 1; m_match = 0; m_exp = tstep(d, m_tap);
          end
        end
        m_prev = d; m_prev_ok = 1;
      end else begin
        if (d != m_exp) begin
          er = 1;
`ifdef PRBS_CHECKER_BITERR_EN
          inc = $countones(d ^ m_exp);
`else
          inc = 1;
`endif
          m_miss++;
          if (m_miss == LOSS) begin
            m_lk = 0; m_prev_ok = 0; m_match = 0; m_miss = 0;
          end
        end else m_miss = 0;
        m_exp = tstep(m_exp, m_tap);
      end
    end
    if (c) m_cnt = 0;
    else m_cnt = (m_cnt + inc > CMAX) ? CMAX : m_cnt + inc;
    e.lk = m_lk; e.er = er; e.cnt = 4'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit c);
    exp_t e;
    din_valid = v; din = d; clr_cnt = c;
    model(v, d, c);
    @(posedge clk); #1;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("locked", int'(locked), int'(e.lk));
      chk("err", int'(err), int'(e.er));
      chk("err_cnt", int'(err_cnt), int'(e.cnt));
    end
    din_valid = 0; clr_cnt = 0;
  endtask

  task automatic gen(output logic [7:0] w);
    w = g; g = tstep(g, m_tap);
  endtask

  task automatic send_clean();
    logic [7:0] w;
    gen(w); cyc(1, w, 0);
  endtask

  task automatic send_xor(input logic [7:0] x, input bit c);
    logic [7:0] w;
    gen(w); cyc(1, w ^ x, c);
  endtask

  task automatic wait_lock(input string tag);
    int n;
    n = 0;
    while (n < 100 && !locked) begin send_clean(); n++; end
    chk(tag, n, LOCK + 1);
  endtask

  // Called right after a cyc (posedge+1): asynchronous assert, check, release.
  task automatic rst_pulse(input string tag);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_cnt"}, int'(err_cnt), 0);
    model_reset();
    sb.delete();
    #3 rst = 1'b1;
  endtask

  function automatic bit a5_ahead();
    logic [7:0] w;
    w = g;
    for (int i = 0; i < LOSS; i++) begin
      if (w == 8'hA5) return 1;
      w = tstep(w, m_tap);
    end
    return 0;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; tap = 8'h1D; m_tap = 8'h1D; g = 8'h01;
    din_valid = 0; din = '0; clr_cnt = 0;
    model_reset();
    #3;
    chk("reset_locked", int'(locked), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_cnt", int'(err_cnt), 0);
    #13 rst = 1'b1;
    @(posedge clk); #1;

    // Clean stream: lock after 17th word, no errors over 1000 words
    wait_lock("lock_words");
    for (int i = 0; i < 1000 - (LOCK + 1); i++) send_clean();
    chk("clean_cnt", int'(err_cnt), 0);
    chk("clean_locked", int'(locked), 1);

    // Single corrupted word
    send_xor(8'h05, 0);
    chk("single_err", int'(err), 1);
    send_clean();
    chk("single_err_drop", int'(err), 0);
    chk("single_lock_held", int'(locked), 1);
`ifdef PRBS_CHECKER_BITERR_EN
    chk("single_cnt", int'(err_cnt), 2);
`else
    chk("single_cnt", int'(err_cnt), 1);
`endif

    // Four consecutive A5 words drop lock on the 4th
    cyc(0, 8'h00, 1);
    while (a5_ahead()) send_clean();
    for (int i = 0; i < LOSS; i++) begin
      if (i == LOSS - 1) chk("loss_held_before", int'(locked), 1);
      gen(din); cyc(1, 8'hA5, 0);
    end
    chk("loss_locked", int'(locked), 0);
`ifndef PRBS_CHECKER_BITERR_EN
    chk("loss_cnt", int'(err_cnt), 4);
`endif
    wait_lock("relock_words");

    // Saturation with lock held, then clear racing an error
    cyc(0, 8'h00, 1);
    for (int i = 0; i < 20; i++) begin
      send_xor(8'h05, 0); send_clean(); send_clean();
    end
    chk("sat_cnt", int'(err_cnt), CMAX);
    chk("sat_locked", int'(locked), 1);
    send_xor(8'h05, 1);
    chk("clr_err", int'(err), 1);
    chk("clr_cnt", int'(err_cnt), 0);

    // Random valid gaps
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = $urandom_range(0, 4);
      for (int k = 0; k < gap; k++) cyc(0, 8'($urandom), 0);
      send_clean();
    end
    chk("gap_cnt", int'(err_cnt), 0);
    chk("gap_locked", int'(locked), 1);

    // Reset while locked with err high and a nonzero count
    send_xor(8'h05, 0);
    chk("pre_rst_err", int'(err), 1);
    rst_pulse("midlock_rst");
    wait_lock("post_rst_lock");

    // Degenerate taps behave like tap 8'h02, seeded through 80->00->03
    for (int t = 0; t < 2; t++) begin
      rst_pulse(t == 0 ? "tap00_rst" : "tapff_rst");
      tap = (t == 0) ? 8'h00 : 8'hFF;
      m_tap = 8'h02; g = 8'h80;
      wait_lock(t == 0 ? "tap00_lock" : "tapff_lock");
      for (int i = 0; i < 60; i++) send_clean();
      chk(t == 0 ? "tap00_cnt" : "tapff_cnt", int'(err_cnt), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
